// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter with a round-robin tie break and a combinational request/response mux to one shared slave.
// Optional slave-stall timeout is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_2m #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int TMO = 255
) (
    input  logic            CLK_I,
    input  logic            RST_I,
    input  logic            M0_CYC_I,
    input  logic            M0_STB_I,
    input  logic            M0_WE_I,
    input  logic            M0_LOCK_I,
    input  logic [AW-1:0]   M0_ADR_I,
    input  logic [DW-1:0]   M0_DAT_I,
    input  logic [DW/8-1:0] M0_SEL_I,
    output logic [DW-1:0]   M0_DAT_O,
    output logic            M0_ACK_O,
    output logic            M0_ERR_O,
    output logic            M0_RTY_O,
    input  logic            M1_CYC_I,
    input  logic            M1_STB_I,
    input  logic            M1_WE_I,
    input  logic            M1_LOCK_I,
    input  logic [AW-1:0]   M1_ADR_I,
    input  logic [DW-1:0]   M1_DAT_I,
    input  logic [DW/8-1:0] M1_SEL_I,
    output logic [DW-1:0]   M1_DAT_O,
    output logic            M1_ACK_O,
    output logic            M1_ERR_O,
    output logic            M1_RTY_O,
    output logic            S_CYC_O,
    output logic            S_STB_O,
    output logic            S_WE_O,
    output logic            S_LOCK_O,
    output logic [AW-1:0]   S_ADR_O,
    output logic [DW-1:0]   S_DAT_O,
    output logic [DW/8-1:0] S_SEL_O,
    input  logic [DW-1:0]   S_DAT_I,
    input  logic            S_ACK_I,
    input  logic            S_ERR_I,
    input  logic            S_RTY_I,
    output logic [1:0]      GNT_O
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last_m1;    // M1 was served last, so M0 wins a simultaneous request
    logic   g_cyc, g_stb;
    logic   tmo_fire;

    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            state   <= IDLE;
            last_m1 <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state != IDLE && state_nxt != state)
                last_m1 <= (state == GNT1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (M0_CYC_I && M1_CYC_I)
                    state_nxt = last_m1 ? GNT0 : GNT1;
                else if (M0_CYC_I)
                    state_nxt = GNT0;
                else if (M1_CYC_I)
                    state_nxt = GNT1;
            end
            GNT0: begin
                if (!M0_CYC_I && !M0_LOCK_I)
                    state_nxt = M1_CYC_I ? GNT1 : IDLE;
            end
            GNT1: begin
                if (!M1_CYC_I && !M1_LOCK_I)
                    state_nxt = M0_CYC_I ? GNT0 : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        g_cyc    = 1'b0;
        g_stb    = 1'b0;
        S_WE_O   = 1'b0;
        S_LOCK_O = 1'b0;
        S_ADR_O  = '0;
        S_DAT_O  = '0;
        S_SEL_O  = '0;
        M0_DAT_O = '0;
        M1_DAT_O = '0;
        M0_ACK_O = 1'b0;
        M0_ERR_O = 1'b0;
        M0_RTY_O = 1'b0;
        M1_ACK_O = 1'b0;
        M1_ERR_O = 1'b0;
        M1_RTY_O = 1'b0;
        GNT_O    = 2'b00;
        case (state)
            GNT0: begin
                GNT_O    = 2'b01;
                g_cyc    = M0_CYC_I;
                g_stb    = M0_STB_I;
                S_WE_O   = M0_WE_I;
                S_LOCK_O = M0_LOCK_I;
                S_ADR_O  = M0_ADR_I;
                S_DAT_O  = M0_DAT_I;
                S_SEL_O  = M0_SEL_I;
                M0_DAT_O = S_DAT_I;
                // Terminations are suppressed while reset is applied so an aborted master sees none.
                M0_ACK_O = S_ACK_I & RST_I;
                M0_ERR_O = (S_ERR_I | tmo_fire) & RST_I;
                M0_RTY_O = S_RTY_I & RST_I;
            end
            GNT1: begin
                GNT_O    = 2'b10;
                g_cyc    = M1_CYC_I;
                g_stb    = M1_STB_I;
                S_WE_O   = M1_WE_I;
                S_LOCK_O = M1_LOCK_I;
                S_ADR_O  = M1_ADR_I;
                S_DAT_O  = M1_DAT_I;
                S_SEL_O  = M1_SEL_I;
                M1_DAT_O = S_DAT_I;
                M1_ACK_O = S_ACK_I & RST_I;
                M1_ERR_O = (S_ERR_I | tmo_fire) & RST_I;
                M1_RTY_O = S_RTY_I & RST_I;
            end
            default: ;
        endcase
    end

    assign S_CYC_O = g_cyc;
    assign S_STB_O = g_cyc & g_stb & ~tmo_fire;

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_C = 8'(TMO);

    logic [7:0] tmo_cnt;
    logic       s_term;

    assign s_term   = S_ACK_I | S_ERR_I | S_RTY_I;
    assign tmo_fire = (state != IDLE) && g_cyc && g_stb && (tmo_cnt == TMO_C);

    always_ff @(posedge CLK_I) begin
        if (!RST_I || state == IDLE || state_nxt != state || tmo_fire || s_term)
            tmo_cnt <= 8'd0;
        else if (g_cyc && g_stb)
            tmo_cnt <= tmo_cnt + 8'd1;
    end
`else
    logic tmo_unused;

    assign tmo_unused = ^8'(TMO);
    assign tmo_fire   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: directed scenarios then randomized traffic, all checked against an ownership/round-robin model.
module tb_wb_arbiter_2m;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TMO_T = 4;
`else
    localparam int TMO_T = 255;
`endif

    logic        clk;
    logic        rst_n;
    logic        m_cyc[2], m_stb[2], m_we[2], m_lock[2];
    logic [31:0] m_adr[2], m_dat[2];
    logic [3:0]  m_sel[2];
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
    logic        s_cyc, s_stb, s_we, s_lock;
    logic [31:0] s_adr, s_dat_o, s_dat_i;
    logic [3:0]  s_sel;
    logic        s_ack, s_err, s_rty;
    logic [1:0]  gnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the slave (0 none, 1 M0, 2 M1), who wins a tie, stall length.
    int own    = 0;
    int prefer = 0;
    int tcnt   = 0;

    wb_arbiter_2m #(.AW(32), .DW(32), .TMO(TMO_T)) dut (
        .CLK_I(clk), .RST_I(rst_n),
        .M0_CYC_I(m_cyc[0]), .M0_STB_I(m_stb[0]), .M0_WE_I(m_we[0]), .M0_LOCK_I(m_lock[0]),
        .M0_ADR_I(m_adr[0]), .M0_DAT_I(m_dat[0]), .M0_SEL_I(m_sel[0]),
        .M0_DAT_O(m0_dat_o), .M0_ACK_O(m0_ack), .M0_ERR_O(m0_err), .M0_RTY_O(m0_rty),
        .M1_CYC_I(m_cyc[1]), .M1_STB_I(m_stb[1]), .M1_WE_I(m_we[1]), .M1_LOCK_I(m_lock[1]),
        .M1_ADR_I(m_adr[1]), .M1_DAT_I(m_dat[1]), .M1_SEL_I(m_sel[1]),
        .M1_DAT_O(m1_dat_o), .M1_ACK_O(m1_ack), .M1_ERR_O(m1_err), .M1_RTY_O(m1_rty),
        .S_CYC_O(s_cyc), .S_STB_O(s_stb), .S_WE_O(s_we), .S_LOCK_O(s_lock),
        .S_ADR_O(s_adr), .S_DAT_O(s_dat_o), .S_SEL_O(s_sel),
        .S_DAT_I(s_dat_i), .S_ACK_I(s_ack), .S_ERR_I(s_err), .S_RTY_I(s_rty),
        .GNT_O(gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic fire_exp();
`ifdef WB_ARB_TIMEOUT_EN
        if (own == 0) return 1'b0;
        return m_cyc[own-1] && m_stb[own-1] && (tcnt == TMO_T);
`else
        return 1'b0;
`endif
    endfunction

    task automatic compare_all();
        logic [71:0] es;
        logic [5:0]  et;
        logic [31:0] d0, d1;
        logic [2:0]  tm;
        logic        f;
        int          g;
        es = '0; et = '0; d0 = '0; d1 = '0;
        f = fire_exp();
        if (own != 0) begin
            g  = own - 1;
            es = {m_cyc[g], m_stb[g] & m_cyc[g] & ~f, m_we[g], m_lock[g], m_adr[g], m_dat[g], m_sel[g]};
            tm = {rst_n & s_ack, rst_n & (s_err | f), rst_n & s_rty};
            if (g == 0) begin et[5:3] = tm; d0 = s_dat_i; end
            else        begin et[2:0] = tm; d1 = s_dat_i; end
        end
        chk("gnt", gnt, (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00);
        chk("s_bus", {s_cyc, s_stb, s_we, s_lock, s_adr, s_dat_o, s_sel}, es);
        chk("m_term", {m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}, et);
        chk("m0_dat", m0_dat_o, d0);
        chk("m1_dat", m1_dat_o, d1);
    endtask

    task automatic model_update();
        int   nown, g;
        logic f, term;
        f    = fire_exp();
        term = s_ack | s_err | s_rty;
        if (!rst_n) begin
            own = 0; prefer = 0; tcnt = 0;
            return;
        end
        nown = own;
        if (own == 0) begin
            if (m_cyc[0] && m_cyc[1]) nown = prefer + 1;
            else if (m_cyc[0])        nown = 1;
            else if (m_cyc[1])        nown = 2;
        end else begin
            g = own - 1;
            if (!m_cyc[g] && !m_lock[g]) begin
                prefer = 1 - g;
                nown   = m_cyc[1-g] ? 2 - g : 0;
            end
        end
        if (own == 0 || nown != own || f || term) tcnt = 0;
        else if (m_cyc[own-1] && m_stb[own-1])    tcnt++;
        own = nown;
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic probe();
        #3;
        compare_all();
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1;
        for (int m = 0; m < 2; m++) begin
            m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0; m_lock[m] = 1'b0;
            m_adr[m] = '0;   m_dat[m] = '0;   m_sel[m] = '0;
        end
        s_dat_i = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        adv();
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        adv();
        adv();
        rst_n = 1'b1;
        probe();
        chk("reset_gnt", gnt, 2'b00);
        adv();

        // single M0 write, slave acks after two wait cycles
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
        m_adr[0] = 32'h10; m_dat[0] = 32'hA5A5A5A5; m_sel[0] = 4'hF;
        probe(); chk("wr_req_gnt", gnt, 2'b00); adv();
        probe(); chk("wr_gnt", gnt, 2'b01); chk("wr_adr", s_adr, 32'h10); adv();
        probe(); adv();
        s_ack = 1'b1;
        probe(); chk("wr_m0_ack", m0_ack, 1'b1); chk("wr_m1_ack", m1_ack, 1'b0); adv();
        s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_we[0] = 1'b0;
        probe(); chk("wr_ack_drop", m0_ack, 1'b0); adv();

        // simultaneous request after reset, then direct handover
        do_reset();
        s_ack = 1'b1;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        probe(); adv();
        probe(); chk("tie_m0_first", gnt, 2'b01); adv();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        probe(); chk("tie_hold", gnt, 2'b01); adv();
        probe(); chk("tie_switch", gnt, 2'b10);

        // M1 lock bridges a gap in its CYC while M0 waits
        m_lock[1] = 1'b1; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        adv();
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        probe(); adv();
        probe(); chk("lock_gap", gnt, 2'b10);
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        adv();
        probe(); chk("lock_second", gnt, 2'b10);
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_lock[1] = 1'b0;
        adv();
        probe(); chk("lock_release", gnt, 2'b01);

        // M1 read data routing
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0;
        s_ack = 1'b0;
        adv();
        s_dat_i = 32'h12345678; s_ack = 1'b1;
        probe(); chk("rd_gnt", gnt, 2'b10); chk("rd_m1_dat", m1_dat_o, 32'h12345678);
        chk("rd_m0_dat", m0_dat_o, 32'h0); chk("rd_m1_ack", m1_ack, 1'b1);
        adv();
        s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        probe(); adv();

        // reset in the middle of an M0 transfer
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        probe(); adv();
        probe(); chk("abort_pre_gnt", gnt, 2'b01);
        rst_n = 1'b0; s_ack = 1'b1;
        probe(); chk("abort_no_term", {m0_ack, m0_err, m0_rty}, 3'b000); adv();
        rst_n = 1'b1; s_ack = 1'b0;
        probe(); chk("abort_gnt", gnt, 2'b00); chk("abort_s_cyc", {s_cyc, s_stb}, 2'b00); adv();
        idle_inputs();
        probe(); adv();
        do_reset();

        // stalled slave: error after TMO cycles with the timeout, indefinite hold without
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        probe(); adv();
`ifdef WB_ARB_TIMEOUT_EN
        for (int k = 0; k <= 4; k++) begin
            probe();
            chk("tmo_err", m0_err, (k == 4) ? 1'b1 : 1'b0);
            chk("tmo_stb", s_stb, (k == 4) ? 1'b0 : 1'b1);
            adv();
        end
`else
        for (int k = 0; k < 12; k++) begin
            probe();
            chk("stall_err", m0_err, 1'b0);
            chk("stall_gnt", gnt, 2'b01);
            adv();
        end
`endif
        idle_inputs();
        probe(); adv();

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            for (int m = 0; m < 2; m++) begin
                if (!m_cyc[m]) m_cyc[m] = ($urandom_range(0, 3) == 0);
                else           m_cyc[m] = ($urandom_range(0, 5) != 0);
                m_stb[m]  = m_cyc[m] & ($urandom_range(0, 3) != 0);
                m_lock[m] = ($urandom_range(0, 7) == 0);
                m_we[m]   = 1'($urandom);
                m_adr[m]  = $urandom;
                m_dat[m]  = $urandom;
                m_sel[m]  = 4'($urandom);
            end
            s_dat_i = $urandom;
            s_ack   = ($urandom_range(0, 3) == 0);
            s_err   = ($urandom_range(0, 15) == 0);
            s_rty   = ($urandom_range(0, 15) == 0);
            rst_n   = ($urandom_range(0, 99) != 0);
            probe();
            adv();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
